// File: rtl/mpmc10_state_machine.sv
// Command sequencer: steps one memory transaction for the already-selected channel
// through preset, write-data, read and ack phases. Define MPMC10_RMW_EN for read-modify-write.
module mpmc10_state_machine #(
    parameter int NCH      = 8,
    parameter int CHW      = $clog2(NCH),
    parameter int NAR      = 4,
    parameter int SW       = 6,
    parameter int RESV_LSB = 4,
    parameter int TO_LIMIT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ch_vld,
    input  logic [CHW-1:0]    ch,
    input  logic [NCH-1:0]    acki,
    input  logic [NCH-1:0]    taghit,
    input  logic [NCH-1:0]    cr,
    input  logic [31:0]       adr,
    input  logic [NAR*CHW-1:0] resv_ch,
    input  logic [NAR-1:0]    resv_vld,
    input  logic [NAR*32-1:0] resv_adr,
    input  logic              do_wr,
    input  logic              wdf_rdy,
    input  logic              rdy,
    input  logic              rd_data_valid,
    input  logic [SW-1:0]     num_strips,
    input  logic [SW-1:0]     req_strip_cnt,
    input  logic [SW-1:0]     resp_strip_cnt,
    output logic [3:0]        state,
    output logic              to,
    output logic              busy
);

    localparam int WDW = $clog2(TO_LIMIT + 1);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        PRESET1     = 4'd1,
        PRESET2     = 4'd2,
        PRESET3     = 4'd3,
        WRITE_DATA0 = 4'd4,
        WRITE_DATA1 = 4'd5,
        WRITE_DATA2 = 4'd6,
        WRITE_DATA3 = 4'd7,
        READ_DATA0  = 4'd8,
        READ_DATA1  = 4'd9,
        READ_DATA2  = 4'd10,
        WAIT_NACK   = 4'd11
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [WDW-1:0]  wd_q;
    logic            ch_ok;
    logic            ack_sel;
    logic            hit_sel;
    logic            cr_sel;
    logic            rd_hit;
    logic            resv_match;
    logic            req_last;
    logic            resp_last;
    logic            expire;

    // Channel-indexed terms read as 0 when ch is beyond the configured channel count.
    always_comb begin
        ch_ok     = 32'(ch) < 32'(NCH);
        ack_sel   = ch_ok && acki[ch];
        hit_sel   = ch_ok && taghit[ch];
        cr_sel    = ch_ok && cr[ch];
        rd_hit    = !do_wr && hit_sel;
        req_last  = req_strip_cnt == num_strips;
        resp_last = resp_strip_cnt == num_strips;
        expire    = (state_q != IDLE) && (wd_q == WDW'(TO_LIMIT));
        resv_match = 1'b0;
        for (int i = 0; i < NAR; i++) begin
            if (resv_vld[i] && (resv_ch[i*CHW +: CHW] == ch) &&
                (resv_adr[i*32+RESV_LSB +: 32-RESV_LSB] == adr[31:RESV_LSB]))
                resv_match = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ch_vld && ch_ok && !ack_sel && (!cr_sel || resv_match))
                    state_d = PRESET1;
            end
            PRESET1: state_d = rd_hit ? IDLE : PRESET2;
            PRESET2: state_d = rd_hit ? IDLE : PRESET3;
            PRESET3: begin
                if (do_wr) begin
`ifdef MPMC10_RMW_EN
                    state_d = READ_DATA0;
`else
                    state_d = WRITE_DATA0;
`endif
                end else begin
                    state_d = hit_sel ? IDLE : READ_DATA0;
                end
            end
            WRITE_DATA0: if (wdf_rdy) state_d = WRITE_DATA1;
            WRITE_DATA1: state_d = WRITE_DATA2;
            WRITE_DATA2: if (rdy) state_d = WRITE_DATA3;
            WRITE_DATA3: state_d = req_last ? WAIT_NACK : WRITE_DATA0;
            READ_DATA0:  state_d = READ_DATA1;
            READ_DATA1:  if (rdy && req_last) state_d = READ_DATA2;
            READ_DATA2: begin
                if (rd_data_valid && resp_last) begin
`ifdef MPMC10_RMW_EN
                    state_d = do_wr ? WRITE_DATA0 : WAIT_NACK;
`else
                    state_d = WAIT_NACK;
`endif
                end
            end
            WAIT_NACK: if (!ch_vld || ack_sel) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        // Watchdog expiry overrides every other transition.
        if (expire)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wd_q    <= '0;
            to      <= 1'b0;
        end else begin
            state_q <= state_d;
            to      <= expire;
            if ((state_q == IDLE) || expire)
                wd_q <= '0;
            else
                wd_q <= wd_q + WDW'(1);
        end
    end

    assign state = state_q;
    assign busy  = state_q != IDLE;

endmodule

// File: tb/tb_mpmc10_state_machine.sv
// Self-checking bench for mpmc10_state_machine: behavioural model compared every cycle,
// directed test-plan sequences, then randomized traffic with occasional resets.
`timescale 1ns/1ps
module tb_mpmc10_state_machine;

    localparam int NCH    = 8;
    localparam int CHW    = 3;
    localparam int NAR    = 4;
    localparam int SW     = 6;
    localparam int TO_LIM = 20;
`ifdef MPMC10_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ch_vld;
    logic [CHW-1:0]     ch;
    logic [NCH-1:0]     acki, taghit, cr;
    logic [31:0]        adr;
    logic [NAR*CHW-1:0] resv_ch;
    logic [NAR-1:0]     resv_vld;
    logic [NAR*32-1:0]  resv_adr;
    logic               do_wr, wdf_rdy, rdy, rd_data_valid;
    logic [SW-1:0]      num_strips, req_strip_cnt, resp_strip_cnt;
    logic [3:0]         state;
    logic               to, busy;

    mpmc10_state_machine #(
        .NCH(NCH), .CHW(CHW), .NAR(NAR), .SW(SW), .RESV_LSB(4), .TO_LIMIT(TO_LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_vld(ch_vld), .ch(ch), .acki(acki),
        .taghit(taghit), .cr(cr), .adr(adr), .resv_ch(resv_ch), .resv_vld(resv_vld),
        .resv_adr(resv_adr), .do_wr(do_wr), .wdf_rdy(wdf_rdy), .rdy(rdy),
        .rd_data_valid(rd_data_valid), .num_strips(num_strips),
        .req_strip_cnt(req_strip_cnt), .resp_strip_cnt(resp_strip_cnt),
        .state(state), .to(to), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_q[$];
    int         seq_busy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // behavioural model
    int m_state = 0;
    int m_busy_cyc = 0;
    bit m_to = 1'b0;
    int m_nxt;

    function automatic bit resv_hit();
        for (int i = 0; i < NAR; i++)
            if (resv_vld[i] && resv_ch[i*CHW +: CHW] == ch &&
                resv_adr[i*32+4 +: 28] == adr[31:4])
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_next(input int s);
        bit ok, ack, hit, start, lrq, lrs;
        ok    = int'(ch) < NCH;
        ack   = ok && acki[ch];
        hit   = ok && taghit[ch];
        lrq   = req_strip_cnt == num_strips;
        lrs   = resp_strip_cnt == num_strips;
        start = ch_vld && ok && !ack && (!(ok && cr[ch]) || resv_hit());
        if (s == 0)                  return start ? 1 : 0;
        if (s == 1 || s == 2)        return (!do_wr && hit) ? 0 : s + 1;
        if (s == 3)                  return do_wr ? (RMW ? 8 : 4) : (hit ? 0 : 8);
        if (s == 4)                  return wdf_rdy ? 5 : 4;
        if (s == 5)                  return 6;
        if (s == 6)                  return rdy ? 7 : 6;
        if (s == 7)                  return lrq ? 11 : 4;
        if (s == 8)                  return 9;
        if (s == 9)                  return (rdy && lrq) ? 10 : 9;
        if (s == 10)                 return (rd_data_valid && lrs) ? ((RMW && do_wr) ? 4 : 11) : 10;
        if (s == 11)                 return (!ch_vld || ack) ? 0 : 11;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_state    = 0;
            m_busy_cyc = 0;
            m_to       = 1'b0;
        end
        check("model_state", 32'(state), 32'(m_state));
        check("model_to", 32'(to), 32'(m_to));
        check("model_busy", 32'(busy), 32'(m_state != 0));
        if (rst_n) begin
            m_nxt = model_next(m_state);
            if (m_state != 0) m_busy_cyc++;
            m_to = (m_busy_cyc == TO_LIM + 1);
            if (m_to) m_nxt = 0;
            if (m_nxt == 0) m_busy_cyc = 0;
            m_state = m_nxt;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ch_vld = 0; ch = '0; acki = '0; taghit = '0; cr = '0; adr = '0;
        resv_ch = '0; resv_vld = '0; resv_adr = '0; do_wr = 0; wdf_rdy = 0;
        rdy = 0; rd_data_valid = 0; num_strips = '0; req_strip_cnt = '0; resp_strip_cnt = '0;
    endtask

    task automatic expect_seq(input string name);
        logic [3:0] e;
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            check(name, 32'(state), 32'(e));
            if (busy) seq_busy++;
        end
    endtask

    task automatic randomize_inputs();
        ch_vld        = $urandom_range(0, 9) != 0;
        ch            = CHW'($urandom_range(0, NCH - 1));
        acki          = NCH'($urandom & $urandom & $urandom);
        taghit        = NCH'($urandom & $urandom & $urandom & $urandom);
        cr            = NCH'($urandom & $urandom);
        adr           = {($urandom_range(0, 1) != 0) ? 28'h1234567 : 28'h1234568, 4'($urandom)};
        resv_vld      = NAR'($urandom);
        for (int i = 0; i < NAR; i++) begin
            resv_ch[i*CHW +: CHW] = CHW'($urandom_range(0, NCH - 1));
            resv_adr[i*32 +: 32]  = {($urandom_range(0, 1) != 0) ? 28'h1234567 : 28'h1234568, 4'($urandom)};
        end
        do_wr          = $urandom_range(0, 1) != 0;
        wdf_rdy        = $urandom_range(0, 3) != 0;
        rdy            = $urandom_range(0, 1) != 0;
        rd_data_valid  = $urandom_range(0, 1) != 0;
        num_strips     = SW'($urandom_range(0, 2));
        req_strip_cnt  = SW'($urandom_range(0, 2));
        resp_strip_cnt = SW'($urandom_range(0, 2));
    endtask

    int hold, to_seen;

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_to", 32'(to), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // read, no hit, single beat
        ch_vld = 1; ch = 3'd2; rdy = 1; rd_data_valid = 1;
        seq_busy = 0;
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11};
        expect_seq("rd_seq");
        acki[2] = 1'b1;
        exp_q = '{4'd0};
        expect_seq("rd_seq_end");
        check("rd_busy_cycles", 32'(seq_busy), 32'd7);
        clear_inputs();
        step();

        // read aborted by tag hit in PRESET2
        ch_vld = 1; ch = 3'd3;
        exp_q = '{4'd1, 4'd2};
        expect_seq("hit_seq");
        taghit[3] = 1'b1; ch_vld = 0;
        exp_q = '{4'd0, 4'd0};
        expect_seq("hit_abort");
        clear_inputs();

        // three-strip write
        ch_vld = 1; ch = 3'd4; do_wr = 1; wdf_rdy = 1; rdy = 1; num_strips = 6'd2;
        seq_busy = 0;
        exp_q = '{4'd1, 4'd2, 4'd3};
        expect_seq("wr_seq");
        for (int p = 0; p < 3; p++) begin
            exp_q = '{4'd4};
            expect_seq("wr_pass");
            req_strip_cnt = SW'(p);
            exp_q = '{4'd5, 4'd6, 4'd7};
            expect_seq("wr_pass");
        end
        exp_q = '{4'd11};
        expect_seq("wr_nack");
        acki[4] = 1'b1;
        exp_q = '{4'd0};
        expect_seq("wr_end");
        check("wr_busy_cycles", 32'(seq_busy), 32'd16);
        clear_inputs();
        step();

        // conditional store reservations
        ch_vld = 1; ch = 3'd1; cr[1] = 1'b1; do_wr = 1; adr = 32'h1234_5670;
        resv_vld = 4'b0001; resv_ch[2:0] = 3'd1; resv_adr[31:0] = 32'h1234_567C;
        exp_q = '{4'd1};
        expect_seq("resv_match");
        do_wr = 0; taghit[1] = 1'b1;
        exp_q = '{4'd0};
        expect_seq("p1_abort");
        taghit = '0; do_wr = 1; resv_ch[2:0] = 3'd2;
        exp_q = '{4'd0, 4'd0};
        expect_seq("resv_wrong_ch");
        resv_ch[2:0] = 3'd1; resv_adr[31:0] = 32'h1234_5660;
        exp_q = '{4'd0, 4'd0};
        expect_seq("resv_wrong_adr");
        resv_vld = 4'b1000; resv_ch[11:9] = 3'd1; resv_adr[127:96] = 32'h1234_567F;
        exp_q = '{4'd1};
        expect_seq("resv_entry3");
        do_wr = 0; taghit[1] = 1'b1; ch_vld = 0;
        exp_q = '{4'd0};
        expect_seq("resv_exit");
        clear_inputs();

        // watchdog on a stalled read
        ch_vld = 1; ch = 3'd5;
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd8, 4'd9};
        expect_seq("wd_seq");
        hold = 1; to_seen = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (state != 4'd9) break;
            hold++;
            if (to) to_seen++;
        end
        check("wd_hold_cycles", 32'(hold), 32'd17);
        check("wd_state", 32'(state), 32'd0);
        check("wd_to_pulse", 32'(to), 32'd1);
        check("wd_to_early", 32'(to_seen), 32'd0);
        ch_vld = 0;
        step();
        check("wd_to_clear", 32'(to), 32'd0);

        // asynchronous reset mid READ_DATA1
        ch_vld = 1; ch = 3'd6;
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd8, 4'd9};
        expect_seq("rst_seq");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        ch_vld = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_state", 32'(state), 32'd0);

`ifdef MPMC10_RMW_EN
        // read-modify-write, single strip
        clear_inputs();
        ch_vld = 1; ch = 3'd0; do_wr = 1; wdf_rdy = 1; rdy = 1; rd_data_valid = 1;
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd4, 4'd5, 4'd6, 4'd7, 4'd11};
        expect_seq("rmw_seq");
        acki[0] = 1'b1;
        exp_q = '{4'd0};
        expect_seq("rmw_end");
`endif

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst_n = $urandom_range(0, 499) != 0;
            randomize_inputs();
            step();
        end
        rst_n = 1'b1;
        clear_inputs();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mpmc10_state_machine.md
# mpmc10_state_machine

Parametrised command sequencer for the multi-port memory controller. It arbitrates nothing; it takes the already-selected channel and steps one memory transaction through preset, write-data, read-request/response and acknowledge phases. It generalises channel count, reservation depth and strip-count width, and adds four things: an internal hang watchdog, multi-strip write looping, an acknowledge wait, and optional read-modify-write sequencing. It sits between the channel arbiter/cache tag logic and the DDR app interface driver.

## Interface
Parameters:
- NCH, 8, number of channels (2..16)
- CHW, $clog2(NCH), channel index width
- NAR, 4, number of address-reservation entries
- SW, 6, strip counter width
- RESV_LSB, 4, lowest address bit compared for reservations
- TO_LIMIT, 1023, watchdog limit in cycles (counter width $clog2(TO_LIMIT+1))

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ch_vld  in  1  a channel is selected
- ch  in  CHW  selected channel index
- acki  in  NCH  per-channel ack currently driven to the client
- taghit  in  NCH  per-channel read-cache tag hit
- cr  in  NCH  per-channel conditional (reserved) store request
- adr  in  32  address of the selected channel's request
- resv_ch  in  NAR*CHW  reservation owner, entry i at [i*CHW +: CHW]
- resv_vld  in  NAR  reservation entry valid
- resv_adr  in  NAR*32  reservation address, entry i at [i*32 +: 32]
- do_wr  in  1  current request is a write
- wdf_rdy  in  1  write-data FIFO ready
- rdy  in  1  command accepted by memory interface
- rd_data_valid  in  1  read response beat valid
- num_strips  in  SW  last strip index of the burst
- req_strip_cnt  in  SW  strips requested so far
- resp_strip_cnt  in  SW  strips returned so far
- state  out  4  current state encoding
- to  out  1  one-cycle watchdog-expiry pulse
- busy  out  1  state != IDLE

## Operation
- Encodings: IDLE=0, PRESET1=1, PRESET2=2, PRESET3=3, WRITE_DATA0=4, WRITE_DATA1=5, WRITE_DATA2=6, WRITE_DATA3=7, READ_DATA0=8, READ_DATA1=9, READ_DATA2=10, WAIT_NACK=11. Codes 12-15 are illegal and go to IDLE next cycle.
- IDLE: when ch_vld and !acki[ch], go to PRESET1. Exception: if cr[ch], go to PRESET1 only when some entry i has resv_vld[i], resv_ch_i==ch and resv_adr_i[31:RESV_LSB]==adr[31:RESV_LSB]; otherwise stay in IDLE.
- PRESET1/PRESET2: on a read (!do_wr) with taghit[ch], abort to IDLE. Otherwise advance to PRESET2/PRESET3.
- PRESET3: on a write with RMW disabled, go to WRITE_DATA0. On a read with taghit[ch], go to IDLE. Otherwise go to READ_DATA0. The taghit abort applies to reads only.
- WRITE_DATA0 waits for wdf_rdy, then WRITE_DATA1, then WRITE_DATA2. WRITE_DATA2 waits for rdy, then WRITE_DATA3. WRITE_DATA3 goes to WAIT_NACK if req_strip_cnt==num_strips, else back to WRITE_DATA0.
- READ_DATA0 goes to READ_DATA1. READ_DATA1 goes to READ_DATA2 when rdy && req_strip_cnt==num_strips. READ_DATA2 leaves when rd_data_valid && resp_strip_cnt==num_strips: to WAIT_NACK for reads, or to WRITE_DATA0 for RMW writes.
- WAIT_NACK: go to IDLE when !ch_vld, or when acki[ch] is seen. Otherwise hold until the watchdog fires.
- Out-of-range ch (ch ≥ NCH) is treated as no channel: stay in IDLE, and the taghit/acki terms read as 0.
- Strip comparisons are exact SW-bit equality; counters wrapping is the caller's concern.

## Timing
- The state register is the only sequential path for the next-state decision; next state is combinational from the current inputs, so every transition takes effect on the following clock edge.
- Reset: asserting rst_n low immediately forces state=IDLE, to=0, busy=0 and clears the watchdog, with no dependence on clk. Reset mid-transaction abandons it; there is no replay.
- Watchdog: clears every cycle in IDLE and increments every cycle otherwise. When it equals TO_LIMIT:
  - state goes to IDLE on the next edge, overriding all other transitions;
  - to is registered high for exactly that one cycle.
- Minimum latencies, IDLE to IDLE:
  - single-strip write, all ready: 8 cycles;
  - read, rdy immediate, single beat: 7 cycles.
- When a taghit abort and a watchdog expiry coincide, the result is IDLE either way; to still pulses.

## Configuration
- MPMC10_RMW_EN defined: writes at PRESET3 go to READ_DATA0. After the full read response, READ_DATA2 goes to WRITE_DATA0 so merged data is written. Writes never take the taghit abort.
- MPMC10_RMW_EN undefined: writes go directly PRESET3→WRITE_DATA0, and READ_DATA2 always exits to WAIT_NACK.

## Test plan
- Read, no hit, num_strips=0, rdy=1, rd_data_valid in READ_DATA2, acki[ch] high in WAIT_NACK -> sequence 0,1,2,3,8,9,10,11,0; busy high for 7 cycles.
- Read, taghit[3]=1 asserted in PRESET2, ch=3 -> state 0,1,2,0; no READ states entered.
- Write, num_strips=2, wdf_rdy and rdy=1, req_strip_cnt stepping 0,1,2 per WRITE_DATA3 -> three passes through states 4-7, then 11, then 0.
- cr[1]=1, adr=0x1234_5670, one entry {vld, ch=1, 0x1234_567C} -> PRESET1 entered. With the entry's ch=2 instead -> state stays 0.
- Read with rdy held 0 and TO_LIMIT=15 -> state holds 9, to pulses for 1 cycle, then state=0. Drop rst_n mid-READ_DATA1 -> state=0 immediately.
- With MPMC10_RMW_EN, write, single strip -> 0,1,2,3,8,9,10,4,5,6,7,11,0.
